// File: rtl/spi_pkg.sv
// spi_pkg -- shared definitions for the SPI slave framer: FSM state encoding
// and the depth of the pin synchronizers.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/spi_edge_det.sv
// spi_edge_det -- SYNC_DEPTH-flop synchronizer for one asynchronous pin, plus
// single-cycle rise/fall pulses derived from the synchronized level.
module spi_edge_det
    import spi_pkg::*;
#(
    parameter bit RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  prev_q;

    // Synchronizer chain plus one extra flop holding the previous synced level.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync_q <= {SYNC_DEPTH{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], din};
            prev_q <= sync_q[SYNC_DEPTH-1];
        end
    end

    assign level = sync_q[SYNC_DEPTH-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_slave_framer.sv
// spi_slave_framer -- SPI slave receiving {address, data} frames MSB first.
// SCLK, SS and MOSI are synchronized into CLK; all framing uses the synced
// copies, so SCLK half-periods must span at least 4 CLK periods.
// Optional feature macro: SPI_SLAVE_READBACK_EN. When defined, the received
// address is issued on RD_REQ/RD_ADDR and the returned RD_DATA is shifted out
// on MISO during the data phase. When undefined, RD_* is tied off and MISO
// echoes the previous good frame {RX_ADDR, RX_DATA} from the first bit.
module spi_slave_framer
    import spi_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CPOL   = 0,
    parameter int CPHA   = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              SCLK,
    input  logic              SS,
    input  logic              MOSI,
    output logic              MISO,
    output logic [ADDR_W-1:0] RX_ADDR,
    output logic [DATA_W-1:0] RX_DATA,
    output logic              FRAME_VALID,
    output logic              FRAME_ERR,
    output logic              RD_REQ,
    output logic [ADDR_W-1:0] RD_ADDR,
    input  logic [DATA_W-1:0] RD_DATA
);

    localparam int TOT = ADDR_W + DATA_W;
    localparam int CW  = $clog2(TOT + 2);

    localparam logic [CW-1:0] CNT_ADDR_LAST = CW'(ADDR_W - 1);
    localparam logic [CW-1:0] CNT_DATA_LAST = CW'(TOT - 1);
    localparam logic [CW-1:0] CNT_FULL      = CW'(TOT);
    localparam logic [CW-1:0] CNT_SAT       = CW'(TOT + 1);

    // Synced SCLK level right after a sample edge: rising when CPOL==CPHA.
    localparam bit SAMPLE_LVL = (CPOL == CPHA);

    state_t                state, state_nxt;
    logic   [CW-1:0]       cnt;
    logic   [TOT-1:0]      rx_sr, rx_next;
    logic   [TOT-1:0]      tx_sr, tx_nxt;

    logic                  sclk_lvl, sclk_rise, sclk_fall;
    logic                  ss_lvl, ss_rise, ss_fall;
    logic [SYNC_DEPTH-1:0] mosi_sync;
    logic                  mosi_s;
    logic [SYNC_DEPTH-1:0] settle;
    logic                  armed;
    logic                  sclk_edge, sample, shift, shift_ok, in_frame;

    spi_edge_det #(.RST_VAL(CPOL != 0)) u_sclk_det (
        .CLK   (CLK),
        .RST   (RST),
        .din   (SCLK),
        .level (sclk_lvl),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_edge_det #(.RST_VAL(1'b1)) u_ss_det (
        .CLK   (CLK),
        .RST   (RST),
        .din   (SS),
        .level (ss_lvl),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    // MOSI goes through a matching chain so it stays aligned with synced SCLK.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) mosi_sync <= '0;
        else      mosi_sync <= {mosi_sync[SYNC_DEPTH-2:0], MOSI};
    end
    assign mosi_s = mosi_sync[SYNC_DEPTH-1];

    // Arm only after the synced SS reflects the pin and has been seen high, so
    // a reset released mid-frame waits for a genuine SS falling edge.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            settle <= '0;
            armed  <= 1'b0;
        end else begin
            settle <= {settle[SYNC_DEPTH-2:0], 1'b1};
            if (settle[SYNC_DEPTH-1] && ss_lvl) armed <= 1'b1;
        end
    end

    assign sclk_edge = sclk_rise | sclk_fall;
    assign sample    = sclk_edge && (sclk_lvl == SAMPLE_LVL) && (state != IDLE);
    assign shift     = sclk_edge && (sclk_lvl != SAMPLE_LVL) && (state != IDLE);
    // With CPHA=1 the first leading edge presents bit 0, which is already on top.
    assign shift_ok  = shift && ((CPHA == 0) || (cnt != '0));
    assign in_frame  = armed && !ss_lvl;
    assign rx_next   = {rx_sr[TOT-2:0], mosi_s};

    // FSM state register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    // FSM next state; SS rising returns to IDLE from anywhere.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ss_fall && armed) state_nxt = ADDR;
            ADDR:    if (sample && cnt == CNT_ADDR_LAST) state_nxt = DATA;
            DATA:    if (sample && cnt == CNT_DATA_LAST) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (ss_rise) state_nxt = IDLE;
    end

    // Sample counter (saturating) and receive shift register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt   <= '0;
            rx_sr <= '0;
        end else if (state == IDLE) begin
            cnt <= '0;
        end else if (sample) begin
            if (cnt != CNT_SAT)  cnt   <= cnt + CW'(1);
            if (cnt < CNT_FULL)  rx_sr <= rx_next;
        end
    end

    // Frame completion: exact bit count publishes the frame, anything else errors.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            FRAME_VALID <= 1'b0;
            FRAME_ERR   <= 1'b0;
            RX_ADDR     <= '0;
            RX_DATA     <= '0;
        end else begin
            FRAME_VALID <= 1'b0;
            FRAME_ERR   <= 1'b0;
            if (ss_rise && state != IDLE) begin
                if (cnt == CNT_FULL) begin
                    FRAME_VALID <= 1'b1;
                    RX_ADDR     <= rx_sr[TOT-1:DATA_W];
                    RX_DATA     <= rx_sr[DATA_W-1:0];
                end else begin
                    FRAME_ERR <= 1'b1;
                end
            end
        end
    end

`ifdef SPI_SLAVE_READBACK_EN
    logic [1:0] rd_pend;

    // Readback request after the last address sample; RD_DATA is taken two
    // cycles after the RD_REQ pulse.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            RD_REQ  <= 1'b0;
            RD_ADDR <= '0;
            rd_pend <= '0;
        end else begin
            RD_REQ  <= 1'b0;
            rd_pend <= {rd_pend[0], RD_REQ};
            if (state == ADDR && sample && cnt == CNT_ADDR_LAST) begin
                RD_REQ  <= 1'b1;
                RD_ADDR <= rx_next[ADDR_W-1:0];
            end
        end
    end

    // TX word: cleared while idle; the readback word is loaded one slot below
    // the top so the next shift edge puts its MSB on MISO.
    always_comb begin
        tx_nxt = tx_sr;
        if (state == IDLE && ss_lvl) begin
            tx_nxt = '0;
        end else if (rd_pend[1]) begin
            tx_nxt                  = '0;
            tx_nxt[TOT-1]           = tx_sr[TOT-1];
            tx_nxt[TOT-2 -: DATA_W] = RD_DATA;
        end else if (shift_ok) begin
            tx_nxt = tx_sr << 1;
        end
    end
`else
    logic unused_rd_data;
    assign unused_rd_data = ^RD_DATA;
    assign RD_REQ         = 1'b0;
    assign RD_ADDR        = '0;

    // TX word: reloaded with the last good frame while idle, shifted in-frame.
    always_comb begin
        tx_nxt = tx_sr;
        if (state == IDLE && ss_lvl) tx_nxt = {RX_ADDR, RX_DATA};
        else if (shift_ok)           tx_nxt = tx_sr << 1;
    end
`endif

    // TX register and MISO; MISO is forced low whenever SS is high.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            tx_sr <= '0;
            MISO  <= 1'b0;
        end else begin
            tx_sr <= tx_nxt;
            MISO  <= in_frame ? tx_sr[TOT-1] : 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_slave_framer.sv
// tb_spi_slave_framer -- directed bench: four 8/8 instances (one per SPI mode)
// and one 7/16 instance in mode 0, each with its own pins.
module tb_spi_slave_framer;

    localparam int H = 8;  // SCLK half-period in CLK cycles

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sclk [5];
    logic        ss   [5];
    logic        mosi [5];
    logic        miso [5];
    logic        fv   [5];
    logic        fe   [5];
    logic        rdr  [5];
    logic [7:0]  rx_addr [4];
    logic [7:0]  rx_data [4];
    logic [7:0]  rd_addr [4];
    logic [7:0]  rd_data8  = 8'hC3;
    logic [15:0] rd_data16 = 16'h1234;
    logic [6:0]  w_rx_addr, w_rd_addr;
    logic [15:0] w_rx_data;

    int passed = 0, total = 0;
    int fv_cnt [5] = '{default: 0};
    int fe_cnt [5] = '{default: 0};
    int rdr_cnt[5] = '{default: 0};
    int both_cnt = 0;
    logic [7:0] last_rd_addr = 8'h00;

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_slave_framer #(.ADDR_W(8), .DATA_W(8), .CPOL(g / 2), .CPHA(g % 2)) u_dut (
            .CLK(clk), .RST(rst), .SCLK(sclk[g]), .SS(ss[g]), .MOSI(mosi[g]),
            .MISO(miso[g]), .RX_ADDR(rx_addr[g]), .RX_DATA(rx_data[g]),
            .FRAME_VALID(fv[g]), .FRAME_ERR(fe[g]), .RD_REQ(rdr[g]),
            .RD_ADDR(rd_addr[g]), .RD_DATA(rd_data8)
        );
    end

    spi_slave_framer #(.ADDR_W(7), .DATA_W(16), .CPOL(0), .CPHA(0)) u_wide (
        .CLK(clk), .RST(rst), .SCLK(sclk[4]), .SS(ss[4]), .MOSI(mosi[4]),
        .MISO(miso[4]), .RX_ADDR(w_rx_addr), .RX_DATA(w_rx_data),
        .FRAME_VALID(fv[4]), .FRAME_ERR(fe[4]), .RD_REQ(rdr[4]),
        .RD_ADDR(w_rd_addr), .RD_DATA(rd_data16)
    );

    // Pulse monitors, sampled away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 5; i++) begin
            if (fv[i] === 1'b1) fv_cnt[i]++;
            if (fe[i] === 1'b1) fe_cnt[i]++;
            if (rdr[i] === 1'b1) rdr_cnt[i]++;
            if (fv[i] === 1'b1 && fe[i] === 1'b1) both_cnt++;
        end
        if (rdr[0] === 1'b1) last_rd_addr = rd_addr[0];
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // SPI master: sends n bits of 'bits' MSB first; mi collects MISO as the
    // master samples it; fm is MISO 3 CLK after SS falls.
    task automatic spi_frame(input int idx, input logic [63:0] bits, input int n,
                             input bit raise, output logic [63:0] mi, output logic fm);
        logic cpol, cpha;
        cpol = (idx < 4) ? idx[1] : 1'b0;
        cpha = (idx < 4) ? idx[0] : 1'b0;
        mi = '0;
        ss[idx] = 1'b0;
        if (cpha == 1'b0) mosi[idx] = bits[n-1];
        wait_clks(3);
        fm = miso[idx];
        wait_clks(H - 3);
        for (int k = 0; k < n; k++) begin
            if (cpha == 1'b0) begin
                mi = {mi[62:0], miso[idx]};
                sclk[idx] = ~cpol;
                wait_clks(H);
                sclk[idx] = cpol;
                if (k + 1 < n) mosi[idx] = bits[n-2-k];
                wait_clks(H);
            end else begin
                sclk[idx] = ~cpol;
                mosi[idx] = bits[n-1-k];
                wait_clks(H);
                mi = {mi[62:0], miso[idx]};
                sclk[idx] = cpol;
                wait_clks(H);
            end
        end
        if (raise) begin
            ss[idx]   = 1'b1;
            mosi[idx] = 1'b0;
            wait_clks(4 * H);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        wait_clks(4);
        total++; if (rx_addr[0] !== 8'h00) $display("FAIL reset_rx_addr got %h exp 00", rx_addr[0]); else passed++;
        total++; if (rx_data[0] !== 8'h00) $display("FAIL reset_rx_data got %h exp 00", rx_data[0]); else passed++;
        total++; if (fv[0] !== 1'b0 || fe[0] !== 1'b0) $display("FAIL reset_pulses got %b%b exp 00", fv[0], fe[0]); else passed++;
        total++; if (miso[0] !== 1'b0) $display("FAIL reset_miso got %b exp 0", miso[0]); else passed++;
        total++; if (rdr[0] !== 1'b0 || rd_addr[0] !== 8'h00) $display("FAIL reset_rd got %b/%h exp 0/00", rdr[0], rd_addr[0]); else passed++;
        total++; if (w_rx_data !== 16'h0000 || w_rd_addr !== 7'h00) $display("FAIL reset_wide got %h/%h exp 0000/00", w_rx_data, w_rd_addr); else passed++;
        rst = 1'b1;
        wait_clks(4);
        total++; if (miso[0] !== 1'b0) $display("FAIL idle_miso got %b exp 0", miso[0]); else passed++;
    endtask

    task automatic test_basic();
        logic [63:0] mi; logic fm; int v0, e0;
        v0 = fv_cnt[0]; e0 = fe_cnt[0];
        spi_frame(0, {48'h0, 8'hA5, 8'h3C}, 16, 1'b1, mi, fm);
        total++; if (fv_cnt[0] - v0 != 1) $display("FAIL basic_valid got %0d exp 1", fv_cnt[0] - v0); else passed++;
        total++; if (fe_cnt[0] - e0 != 0) $display("FAIL basic_err got %0d exp 0", fe_cnt[0] - e0); else passed++;
        total++; if (rx_addr[0] !== 8'hA5) $display("FAIL basic_rx_addr got %h exp a5", rx_addr[0]); else passed++;
        total++; if (rx_data[0] !== 8'h3C) $display("FAIL basic_rx_data got %h exp 3c", rx_data[0]); else passed++;
    endtask

`ifndef SPI_SLAVE_READBACK_EN
    task automatic test_echo();
        logic [63:0] mi; logic fm;
        spi_frame(0, {48'h0, 8'h11, 8'h22}, 16, 1'b1, mi, fm);
        total++; if (fm !== 1'b1) $display("FAIL echo_first_bit got %b exp 1", fm); else passed++;
        total++; if (mi[15:0] !== 16'hA53C) $display("FAIL echo_miso got %h exp a53c", mi[15:0]); else passed++;
        total++; if (rx_addr[0] !== 8'h11 || rx_data[0] !== 8'h22) $display("FAIL echo_rx got %h%h exp 1122", rx_addr[0], rx_data[0]); else passed++;
        total++; if (rdr_cnt[0] != 0 || rd_addr[0] !== 8'h00) $display("FAIL echo_rd_tied got %0d/%h exp 0/00", rdr_cnt[0], rd_addr[0]); else passed++;
    endtask
`else
    task automatic test_readback();
        logic [63:0] mi; logic fm; int r0;
        r0 = rdr_cnt[0];
        spi_frame(0, {48'h0, 8'h12, 8'h00}, 16, 1'b1, mi, fm);
        total++; if (rdr_cnt[0] - r0 != 1) $display("FAIL rb_req got %0d exp 1", rdr_cnt[0] - r0); else passed++;
        total++; if (last_rd_addr !== 8'h12) $display("FAIL rb_addr got %h exp 12", last_rd_addr); else passed++;
        total++; if (mi[7:0] !== 8'hC3) $display("FAIL rb_miso got %b exp 11000011", mi[7:0]); else passed++;
        total++; if (mi[15:8] !== 8'h00) $display("FAIL rb_addr_phase got %h exp 00", mi[15:8]); else passed++;
    endtask
`endif

    task automatic test_modes();
        logic [63:0] mi; logic fm; int v0;
        for (int m = 0; m < 4; m++) begin
            v0 = fv_cnt[m];
            spi_frame(m, {48'h0, 8'h5A, 8'hF0}, 16, 1'b1, mi, fm);
            total++; if (fv_cnt[m] - v0 != 1) $display("FAIL mode%0d_valid got %0d exp 1", m, fv_cnt[m] - v0); else passed++;
            total++; if (rx_addr[m] !== 8'h5A) $display("FAIL mode%0d_rx_addr got %h exp 5a", m, rx_addr[m]); else passed++;
            total++; if (rx_data[m] !== 8'hF0) $display("FAIL mode%0d_rx_data got %h exp f0", m, rx_data[m]); else passed++;
            spi_frame(m, {48'h0, 8'h5A, 8'hF0}, 16, 1'b1, mi, fm);
`ifndef SPI_SLAVE_READBACK_EN
            total++; if (mi[15:0] !== 16'h5AF0) $display("FAIL mode%0d_echo got %h exp 5af0", m, mi[15:0]); else passed++;
`else
            total++; if (mi[7:0] !== 8'hC3) $display("FAIL mode%0d_rb got %h exp c3", m, mi[7:0]); else passed++;
`endif
        end
    endtask

    task automatic test_bad_length();
        logic [63:0] mi; logic fm; int v0, e0;
        v0 = fv_cnt[0]; e0 = fe_cnt[0];
        spi_frame(0, {53'h0, 11'h7FF}, 11, 1'b1, mi, fm);
        total++; if (fe_cnt[0] - e0 != 1) $display("FAIL short_err got %0d exp 1", fe_cnt[0] - e0); else passed++;
        total++; if (fv_cnt[0] - v0 != 0) $display("FAIL short_valid got %0d exp 0", fv_cnt[0] - v0); else passed++;
        total++; if (rx_addr[0] !== 8'h5A || rx_data[0] !== 8'hF0) $display("FAIL short_rx got %h%h exp 5af0", rx_addr[0], rx_data[0]); else passed++;
        v0 = fv_cnt[0]; e0 = fe_cnt[0];
        spi_frame(0, {47'h0, 17'h1_2345}, 17, 1'b1, mi, fm);
        total++; if (fe_cnt[0] - e0 != 1) $display("FAIL long_err got %0d exp 1", fe_cnt[0] - e0); else passed++;
        total++; if (fv_cnt[0] - v0 != 0) $display("FAIL long_valid got %0d exp 0", fv_cnt[0] - v0); else passed++;
        total++; if (rx_addr[0] !== 8'h5A || rx_data[0] !== 8'hF0) $display("FAIL long_rx got %h%h exp 5af0", rx_addr[0], rx_data[0]); else passed++;
    endtask

    task automatic test_reset_mid_frame();
        logic [63:0] mi; logic fm; int v0, e0;
        v0 = fv_cnt[0]; e0 = fe_cnt[0];
        spi_frame(0, {48'h0, 8'hFF, 8'hFF}, 6, 1'b0, mi, fm);
        rst = 1'b0;
        wait_clks(3);
        total++; if (rx_addr[0] !== 8'h00) $display("FAIL mid_reset_rx got %h exp 00", rx_addr[0]); else passed++;
        rst = 1'b1;
        wait_clks(2 * H);
        ss[0] = 1'b1;
        wait_clks(4 * H);
        total++; if (fv_cnt[0] - v0 != 0 || fe_cnt[0] - e0 != 0) $display("FAIL mid_reset_pulses got %0d/%0d exp 0/0", fv_cnt[0] - v0, fe_cnt[0] - e0); else passed++;
        spi_frame(0, {48'h0, 8'h01, 8'h02}, 16, 1'b1, mi, fm);
        total++; if (fv_cnt[0] - v0 != 1) $display("FAIL after_reset_valid got %0d exp 1", fv_cnt[0] - v0); else passed++;
        total++; if (rx_addr[0] !== 8'h01 || rx_data[0] !== 8'h02) $display("FAIL after_reset_rx got %h%h exp 0102", rx_addr[0], rx_data[0]); else passed++;
    endtask

    task automatic test_wide();
        logic [63:0] mi; logic fm; int v0;
        v0 = fv_cnt[4];
        spi_frame(4, {41'h0, 7'h7F, 16'hBEEF}, 23, 1'b1, mi, fm);
        total++; if (fv_cnt[4] - v0 != 1) $display("FAIL wide_valid got %0d exp 1", fv_cnt[4] - v0); else passed++;
        total++; if (w_rx_addr !== 7'h7F) $display("FAIL wide_rx_addr got %h exp 7f", w_rx_addr); else passed++;
        total++; if (w_rx_data !== 16'hBEEF) $display("FAIL wide_rx_data got %h exp beef", w_rx_data); else passed++;
        spi_frame(4, {41'h0, 7'h7F, 16'hBEEF}, 23, 1'b1, mi, fm);
`ifndef SPI_SLAVE_READBACK_EN
        total++; if (mi[22:0] !== {7'h7F, 16'hBEEF}) $display("FAIL wide_echo got %h exp 7fbeef", mi[22:0]); else passed++;
`else
        total++; if (mi[15:0] !== 16'h1234) $display("FAIL wide_rb got %h exp 1234", mi[15:0]); else passed++;
`endif
    endtask

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sclk[i] = (i < 4) ? i[1] : 1'b0;
            ss[i]   = 1'b1;
            mosi[i] = 1'b0;
        end
        test_reset();
        test_basic();
`ifndef SPI_SLAVE_READBACK_EN
        test_echo();
`else
        test_readback();
`endif
        test_modes();
        test_bad_length();
        test_reset_mid_frame();
        test_wide();
        total++; if (both_cnt != 0) $display("FAIL valid_and_err_together got %0d exp 0", both_cnt); else passed++;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/spi_slave_framer.md
SPI_SLAVE_FRAMER -- requirements
Module: spi_slave_framer

Interface
- REQ-001 SHALL have parameter ADDR_W, default 8: address field width in bits (1..16).
- REQ-002 SHALL have parameter DATA_W, default 8: data field width in bits (1..32).
- REQ-003 SHALL have parameter CPOL, default 0: SCLK idle level.
- REQ-004 SHALL have parameter CPHA, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- REQ-005 SHALL have port CLK, input, 1: system clock.
- REQ-006 SHALL have port RST, input, 1: asynchronous, active-low reset.
- REQ-007 SHALL have port SCLK, SS, MOSI, input, 1 each: raw SPI pins, asynchronous to CLK; SS is active-low.
- REQ-008 SHALL have port MISO, output, 1: serial readback.
- REQ-009 SHALL have port RX_ADDR, output, ADDR_W: address of the last valid frame.
- REQ-010 SHALL have port RX_DATA, output, DATA_W: data of the last valid frame.
- REQ-011 SHALL have port FRAME_VALID, output, 1: one-cycle pulse on completion of a good frame.
- REQ-012 SHALL have port FRAME_ERR, output, 1: one-cycle pulse when a frame ends with the wrong bit count.
- REQ-013 SHALL have port RD_REQ, output, 1: one-cycle readback request.
- REQ-014 SHALL have port RD_ADDR, output, ADDR_W: address accompanying RD_REQ.
- REQ-015 SHALL have port RD_DATA, input, DATA_W: readback word, valid 2 CLK after RD_REQ.

Function
- REQ-016 SHALL pass SCLK, SS and MOSI through 2-flop synchronizers; all edge detection SHALL use the synchronized signals.
- REQ-017 SHALL sample MOSI on the rising synced SCLK edge when CPOL==CPHA, and on the falling edge otherwise.
- REQ-018 SHALL shift MISO on the edge opposite the sample edge, MSB first.
- REQ-019 SHALL receive a frame MSB first as ADDR_W address bits followed by DATA_W data bits.
- REQ-020 SHALL implement FSM states IDLE, ADDR, DATA, DONE:
  - IDLE->ADDR on SS falling;
  - ADDR->DATA after the ADDR_W-th sample;
  - DATA->DONE after the (ADDR_W+DATA_W)-th sample;
  - any state->IDLE on SS rising.
- REQ-021 SHALL count samples with a counter of width clog2(ADDR_W+DATA_W+2), saturating at ADDR_W+DATA_W+1.
- REQ-022 SHALL pulse FRAME_VALID and update RX_ADDR/RX_DATA one CLK after synced SS rising, if and only if the count equals ADDR_W+DATA_W.
- REQ-023 SHALL, on SS rising with count not equal to ADDR_W+DATA_W (short or long frame), pulse FRAME_ERR and leave RX_ADDR/RX_DATA unchanged.
- REQ-024 SHALL ignore SCLK edges while synced SS is high.
- REQ-025 SHALL never assert FRAME_VALID and FRAME_ERR in the same cycle.
- REQ-026 SHALL require an SCLK half-period of at least 4 CLK periods; behaviour below this limit is undefined.
- REQ-027 SHALL drive MISO to 0 outside a frame (SS high).

Reset
- REQ-028 SHALL on RST low: FSM to IDLE, counter to 0, all shift registers to 0, and RX_ADDR, RX_DATA, RD_ADDR, FRAME_VALID, FRAME_ERR, RD_REQ and MISO to 0.
- REQ-029 SHALL reset the SS synchronizer to 1 and the SCLK synchronizer to CPOL.
- REQ-030 SHALL, on reset mid-frame, emit no pulse on release and wait for the next SS falling edge before accepting a frame.

Configuration
- REQ-031 SHALL recognise macro SPI_SLAVE_READBACK_EN.
- REQ-032 SHALL, with SPI_SLAVE_READBACK_EN defined:
  - pulse RD_REQ with RD_ADDR = the received address in the cycle after the ADDR_W-th sample;
  - capture RD_DATA exactly 2 CLK later into the TX shift register;
  - shift the captured word out on MISO during the DATA phase, MSB first.
- REQ-033 SHALL, with SPI_SLAVE_READBACK_EN undefined, tie RD_REQ and RD_ADDR to 0, ignore RD_DATA, and echo the previous frame's {RX_ADDR,RX_DATA} on MISO, MSB first, from the first bit of each frame.
- REQ-034 SHALL, for CPHA=0, present the first MISO bit within 3 CLK of SS falling, before the first sample edge.

Structure
- REQ-035 SHALL take the state encoding typedef (IDLE/ADDR/DATA/DONE) and the sync depth constant (2) from shared package spi_pkg.
- REQ-036 SHALL instantiate sub-module spi_edge_det (synchronizer plus rising/falling pulse outputs) once for SCLK and once for SS.

Verification
- REQ-037 SHALL cover: mode 0, 8/8 widths, frame 0xA5,0x3C -> FRAME_VALID once, RX_ADDR=0xA5, RX_DATA=0x3C.
- REQ-038 SHALL cover: all four CPOL/CPHA combinations sending 0x5A,0xF0 -> identical RX values in each mode.
- REQ-039 SHALL cover: SS raised after 11 bits -> FRAME_ERR once, no FRAME_VALID, RX unchanged; 17 bits -> FRAME_ERR.
- REQ-040 SHALL cover: READBACK_EN, address 0x12, RD_DATA=0xC3 -> RD_REQ with RD_ADDR=0x12, MISO bits during data phase = 11000011.
- REQ-041 SHALL cover: RST asserted after 6 bits, then released -> no pulses; next full frame 0x01,0x02 is received correctly.
- REQ-042 SHALL cover: ADDR_W=7, DATA_W=16, frame 0x7F,0xBEEF -> RX_ADDR=0x7F, RX_DATA=0xBEEF.
